// File: rtl/pc_redirect_ctrl_if.sv
// Fetch-side bundle between branch resolution, the PC controller and instruction memory.
// The master drives resolution/hazard inputs; the slave (PC controller) drives fetch outputs.
interface pc_redirect_ctrl_if #(
  parameter int N = 16
);
  logic         stall;
  logic         brValid;
  logic         takeBranch;
  logic [N-1:0] target;
  logic         halt;
  logic [N-1:0] pc;
  logic [N-1:0] pcPlus2;
  logic         fetchValid;
  logic         flush;
  logic         misalign;
  logic         halted;

  modport master (
    output stall, brValid, takeBranch, target, halt,
    input  pc, pcPlus2, fetchValid, flush, misalign, halted
  );

  modport slave (
    input  stall, brValid, takeBranch, target, halt,
    output pc, pcPlus2, fetchValid, flush, misalign, halted
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Architectural PC owner: sequential fetch, taken-branch redirect with a wrong-path
// flush window, hazard stall and sticky halt. All outputs come from registered state.
module pc_redirect_ctrl #(
  parameter int           N            = 16,
  parameter logic [N-1:0] RESET_PC     = 16'h0000,
  parameter int           FLUSH_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  pc_redirect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [N-1:0] PC_STEP  = N'(2);

  state_t       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         misalign_q, misalign_d;
  logic         redirect;

  assign redirect = bus.brValid & bus.takeBranch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      cnt_q      <= 3'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
    end
  end

  // Halt beats redirect; redirect ignores stall because the resolving instruction is older.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.halt) begin
          state_d = HALT;
        end else if (redirect) begin
          pc_d       = {bus.target[N-1:1], 1'b0};
          cnt_d      = FLUSH_LOAD;
          state_d    = FLUSH;
          misalign_d = bus.target[0];
        end else if (!bus.stall) begin
          pc_d = pc_q + PC_STEP;
        end
      end
      FLUSH: begin
        // A branch resolving here is itself wrong-path, so brValid is not consulted.
        if (bus.halt) begin
          state_d = HALT;
          cnt_d   = 3'd0;
        end else begin
          if (!bus.stall) begin
            pc_d = pc_q + PC_STEP;
          end
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

  assign bus.pc         = pc_q;
  assign bus.pcPlus2    = pc_q + PC_STEP;
  assign bus.fetchValid = (state_q != HALT);
  assign bus.flush      = (state_q == FLUSH);
  assign bus.misalign   = misalign_q;
  assign bus.halted     = (state_q == HALT);

endmodule
